// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Framed byte-stream program loader. Accepts SYNC, LEN, LEN
//                payload bytes and (optionally) a CHK byte over a valid/ready
//                handshake, writes the payload into instruction memory and
//                raises cpu_run only after a complete, good frame.
//  Options     : LOADER_CHECKSUM_EN - when defined, a trailing CHK byte is
//                expected and (sum of payload + CHK) mod 256 must be zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int         ADDR_W = 7,
    parameter int         DEPTH  = 32,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,      // asynchronous, active-high
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    // WR is the mem_we cycle of a payload byte; it belongs to the DATA phase.
    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_LEN  = 3'd1;
    localparam logic [2:0] C_DATA = 3'd2;
    localparam logic [2:0] C_WR   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] C_CHK  = 3'd4;
`endif
    localparam logic [2:0] C_DONE = 3'd5;
    localparam logic [2:0] C_ERR  = 3'd6;

    localparam logic [7:0] C_DEPTH = 8'(DEPTH);

    localparam logic [1:0] C_ERR_NONE = 2'd0;
    localparam logic [1:0] C_ERR_LEN  = 2'd1;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] C_ERR_CHK  = 2'd2;
`endif

    logic [2:0] state_q, state_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] len_q,   len_d;
    logic [7:0] byte_q,  byte_d;
    logic [1:0] err_code_q, err_code_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q,   sum_d;
    logic [7:0] w_chk_total;
`endif

    logic       w_take;
    logic       w_sync;
    logic       w_len_bad;
    logic       w_last;
    logic [7:0] w_idx_inc;

    assign w_take    = rx_valid & rx_ready;
    assign w_sync    = w_take & (rx_data == SYNC);
    assign w_len_bad = (rx_data == 8'd0) || (rx_data > C_DEPTH);
    assign w_idx_inc = idx_q + 8'd1;
    // The write in flight is the LEN-th one when idx+1 reaches LEN.
    assign w_last    = (w_idx_inc == len_q);
`ifdef LOADER_CHECKSUM_EN
    assign w_chk_total = sum_q + rx_data;
`endif

    // Outputs are decoded directly from the registered state so cpu_run
    // drops on the same edge the state leaves DONE.
    assign rx_ready  = (state_q != C_WR);
    assign mem_we    = (state_q == C_WR);
    assign mem_addr  = ADDR_W'(idx_q);
    assign mem_wdata = byte_q;
    assign cpu_run   = (state_q == C_DONE);
    assign err       = (state_q == C_ERR);
`ifdef LOADER_CHECKSUM_EN
    assign busy      = (state_q == C_LEN) || (state_q == C_DATA) ||
                       (state_q == C_WR)  || (state_q == C_CHK);
`else
    assign busy      = (state_q == C_LEN) || (state_q == C_DATA) ||
                       (state_q == C_WR);
`endif
    assign err_code  = err_code_q;

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        byte_d     = byte_q;
        err_code_d = err_code_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            C_IDLE, C_DONE, C_ERR: begin
                // Only SYNC is meaningful while waiting; everything else is dropped.
                if (w_sync) begin
                    state_d    = C_LEN;
                    idx_d      = 8'd0;
                    err_code_d = C_ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            C_LEN: begin
                if (w_take) begin
                    if (w_len_bad) begin
                        state_d    = C_ERR;
                        err_code_d = C_ERR_LEN;
                    end else begin
                        len_d   = rx_data;
                        state_d = C_DATA;
                    end
                end
            end
            C_DATA: begin
                if (w_take) begin
                    byte_d  = rx_data;
                    state_d = C_WR;
                end
            end
            C_WR: begin
                idx_d = w_idx_inc;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = sum_q + byte_q;
                state_d = w_last ? C_CHK : C_DATA;
`else
                state_d = w_last ? C_DONE : C_DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            C_CHK: begin
                if (w_take) begin
                    if (w_chk_total == 8'd0) begin
                        state_d = C_DONE;
                    end else begin
                        state_d    = C_ERR;
                        err_code_d = C_ERR_CHK;
                    end
                end
            end
`endif
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= C_IDLE;
            idx_q      <= 8'd0;
            len_q      <= 8'd0;
            byte_q     <= 8'd0;
            err_code_q <= C_ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            byte_q     <= byte_d;
            err_code_q <= err_code_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Frames are built at the
//                byte level; expected writes go into a scoreboard queue that a
//                monitor drains on every mem_we, and frame status is checked
//                after each frame. Honours LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int         ADDR_W = 7;
    localparam int         DEPTH  = 32;
    localparam logic [7:0] C_SYNC = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit         CHK_EN = 1'b1;
`else
    localparam bit         CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    wr_t        exp_q[$];
    logic [7:0] jq[$];
    logic [7:0] pq[$];
    int         errors = 0;
    int         checks = 0;
    bit         done = 1'b0;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC(C_SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  sent;
        n    = 0;
        sent = 1'b0;
        while (!sent && n < 20) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                sent = 1'b1;
            end
            n++;
        end
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: byte %0h not accepted in 20 cycles", b);
        end
        if ($urandom_range(0, 3) == 0) idle(1);
    endtask

    task automatic status(input string tag, input bit e_run, input bit e_err, input logic [1:0] e_code);
        idle(4);
        check({tag, ".cpu_run"},  32'(cpu_run),  32'(e_run));
        check({tag, ".err"},      32'(err),      32'(e_err));
        check({tag, ".err_code"}, 32'(err_code), 32'(e_code));
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    // Send junk, SYNC, LEN, payload and CHK; the expected outcome follows from
    // the frame rules alone.
    task automatic frame(input string tag, input logic [7:0] junk[$], input logic [7:0] lenb,
                         input logic [7:0] pl[$], input logic [7:0] chk);
        logic [7:0] s;
        logic [7:0] tot;
        wr_t        w;
        s = 8'd0;
        foreach (junk[i]) send_byte(junk[i]);
        send_byte(C_SYNC);
        send_byte(lenb);
        if (lenb == 8'd0 || int'(lenb) > DEPTH) begin
            status(tag, 1'b0, 1'b1, 2'd1);
            return;
        end
        for (int i = 0; i < int'(lenb); i++) begin
            w.addr = ADDR_W'(i);
            w.data = pl[i];
            exp_q.push_back(w);
            s = s + pl[i];
            send_byte(pl[i]);
        end
        if (CHK_EN) begin
            send_byte(chk);
            tot = s + chk;
            if (tot == 8'd0) status(tag, 1'b1, 1'b0, 2'd0);
            else             status(tag, 1'b0, 1'b1, 2'd2);
        end else begin
            if (chk != C_SYNC) send_byte(chk);
            status(tag, 1'b1, 1'b0, 2'd0);
        end
    endtask

    initial begin
        fork
            // Monitor: every write strobe must match the next expected write.
            begin
                wr_t e;
                while (!done) begin
                    @(negedge clk);
                    if (mem_we === 1'b1) begin
                        check("rx_ready_during_we", 32'(rx_ready), 32'd0);
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                                     mem_addr, mem_wdata);
                        end else begin
                            e = exp_q.pop_front();
                            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                                errors++;
                                $display("FAIL write: got (%0h,%0h) expected (%0h,%0h)",
                                         mem_addr, mem_wdata, e.addr, e.data);
                            end
                        end
                    end
                end
            end
            // Driver.
            begin
                logic [7:0] b;
                logic [7:0] lenb;
                logic [7:0] s;
                logic [7:0] chk;
                int         r;
                wr_t        w;

                repeat (3) @(negedge clk);
                check("reset.rx_ready", 32'(rx_ready), 32'd1);
                check("reset.mem_we",   32'(mem_we),   32'd0);
                check("reset.cpu_run",  32'(cpu_run),  32'd0);
                check("reset.busy",     32'(busy),     32'd0);
                check("reset.err",      32'(err),      32'd0);
                check("reset.err_code", 32'(err_code), 32'd0);
                rst_n = 1'b0;
                idle(2);

                jq.delete(); pq = {8'h01, 8'h05};
                frame("t1", jq, 8'd2, pq, 8'hFA);
                jq = {8'h33, 8'h7E}; pq = {8'h0A};
                frame("t2", jq, 8'd1, pq, 8'hF6);
                jq.delete(); pq = {8'h07};
                frame("t3", jq, 8'd1, pq, 8'h00);
                pq.delete();
                frame("t4a", jq, 8'd0, pq, 8'h00);
                frame("t4b", jq, 8'd33, pq, 8'h00);
                pq = {8'h10, 8'hF0};
                frame("t4c", jq, 8'd2, pq, 8'h00);

                // Reset in the middle of a frame.
                send_byte(C_SYNC);
                send_byte(8'd3);
                w.addr = '0; w.data = 8'h01;
                exp_q.push_back(w);
                send_byte(8'h01);
                idle(2);
                check("t5.busy_before_rst", 32'(busy), 32'd1);
                rst_n = 1'b1;
                @(negedge clk);
                check("t5.busy",    32'(busy),    32'd0);
                check("t5.cpu_run", 32'(cpu_run), 32'd0);
                check("t5.err",     32'(err),     32'd0);
                check("t5.mem_we",  32'(mem_we),  32'd0);
                check("t5.pending", 32'(exp_q.size()), 32'd0);
                @(negedge clk);
                rst_n = 1'b0;
                idle(2);
                pq = {8'h02};
                frame("t5", jq, 8'd1, pq, 8'hFE);

                // Randomized frames.
                for (int f = 0; f < 40; f++) begin
                    jq.delete();
                    pq.delete();
                    r = $urandom_range(0, 2);
                    for (int j = 0; j < r; j++) begin
                        do b = 8'($urandom); while (b == C_SYNC);
                        jq.push_back(b);
                    end
                    r = $urandom_range(0, 9);
                    case (r)
                        0:       lenb = 8'd0;
                        1:       lenb = 8'($urandom_range(33, 255));
                        2:       lenb = 8'd32;
                        3:       lenb = 8'd1;
                        default: lenb = 8'($urandom_range(1, 32));
                    endcase
                    s = 8'd0;
                    for (int j = 0; j < int'(lenb); j++) begin
                        b = 8'($urandom);
                        pq.push_back(b);
                        s = s + b;
                    end
                    chk = 8'd0 - s;
                    if ($urandom_range(0, 2) == 0) chk = chk + 8'($urandom_range(1, 255));
                    frame($sformatf("rnd%0d", f), jq, lenb, pq, chk);
                end

                idle(4);
                done = 1'b1;
            end
        join
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
